// File: rtl/quad_pkg.sv
// Shared constants for the quadrature decoder: FSM encodings, Gray-code states,
// speed saturation limit and synchronizer depth.
package quad_pkg;

  localparam int ST_W = $clog2(2);
  localparam logic [ST_W-1:0] ST_INIT  = 1'b0;
  localparam logic [ST_W-1:0] ST_TRACK = 1'b1;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  localparam logic [3:0] SPEED_MAX   = 4'd15;
  localparam int         SYNC_STAGES = 2;

  // Successor of a channel pair in the forward (clockwise) Gray sequence.
  function automatic logic [1:0] gray_next(input logic [1:0] ab);
    case (ab)
      QS_00:   gray_next = QS_01;
      QS_01:   gray_next = QS_11;
      QS_11:   gray_next = QS_10;
      QS_10:   gray_next = QS_00;
      default: gray_next = QS_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Single-bit stability filter: the output follows the input only after the input
// has differed from the output for FILTER_CYCLES consecutive cycles.
module quad_glitch_filter #(
  parameter int FILTER_CYCLES = 16
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic raw,
  output logic filtered
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             filtered_r;

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt_r      <= '0;
      filtered_r <= 1'b0;
    end else if (raw == filtered_r) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r      <= '0;
      filtered_r <= raw;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign filtered = filtered_r;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder for the paddle encoder: step strobes, direction, windowed speed
// and illegal-jump flag. Optional input glitch filter: QUAD_GLITCH_FILTER_EN.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1_000_000,
  parameter int FILTER_CYCLES = 16
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       ENC_A,
  input  logic       ENC_B,
  output logic       COUNT_ENABLE,
  output logic       DIRECTION,
  output logic [3:0] SPEED,
  output logic       ERROR
);

`ifdef QUAD_GLITCH_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  localparam int INIT_WAIT = SYNC_STAGES + (FILTER_EN ? FILTER_CYCLES : 0);
  localparam int INIT_W    = $clog2(INIT_WAIT + 1);
  localparam int WIN_W     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic [SYNC_STAGES-1:0] a_sync_r, b_sync_r;
  logic [1:0]             ab_s, track_ab_s, diff_s;
  logic                   single_s, double_s;

  logic [ST_W-1:0]   state_r;
  logic [INIT_W-1:0] init_cnt_r;
  logic [1:0]        prev_ab_r;
  logic              count_enable_r, direction_r, error_r;

  logic [WIN_W-1:0]  win_cnt_r;
  logic [3:0]        step_cnt_r, speed_r;
  logic              win_last_s;

  // Two-flop synchronizers for the asynchronous encoder channels.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      a_sync_r <= '0;
      b_sync_r <= '0;
    end else begin
      a_sync_r <= {a_sync_r[SYNC_STAGES-2:0], ENC_A};
      b_sync_r <= {b_sync_r[SYNC_STAGES-2:0], ENC_B};
    end
  end

  assign ab_s = {a_sync_r[SYNC_STAGES-1], b_sync_r[SYNC_STAGES-1]};

`ifdef QUAD_GLITCH_FILTER_EN
  quad_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_a (
    .CLOCK(CLOCK), .RESET(RESET), .raw(ab_s[1]), .filtered(track_ab_s[1])
  );
  quad_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_b (
    .CLOCK(CLOCK), .RESET(RESET), .raw(ab_s[0]), .filtered(track_ab_s[0])
  );
`else
  assign track_ab_s = ab_s;
`endif

  // Classify the change since the last accepted channel pair.
  always_comb begin
    diff_s   = track_ab_s ^ prev_ab_r;
    single_s = 1'b0;
    double_s = 1'b0;
    if (diff_s == 2'b11) begin
      double_s = 1'b1;
    end else if (diff_s != 2'b00) begin
      single_s = 1'b1;
    end else begin
      single_s = 1'b0;
    end
  end

  // Decoder FSM: settle after reset, then emit step / error strobes.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_r        <= ST_INIT;
      init_cnt_r     <= '0;
      prev_ab_r      <= QS_00;
      count_enable_r <= 1'b0;
      direction_r    <= 1'b0;
      error_r        <= 1'b0;
    end else begin
      count_enable_r <= 1'b0;
      error_r        <= 1'b0;
      case (state_r)
        ST_INIT: begin
          if (init_cnt_r == INIT_W'(INIT_WAIT)) begin
            prev_ab_r <= track_ab_s;
            state_r   <= ST_TRACK;
          end else begin
            init_cnt_r <= init_cnt_r + INIT_W'(1);
          end
        end
        ST_TRACK: begin
          if (single_s) begin
            count_enable_r <= 1'b1;
            direction_r    <= (track_ab_s == gray_next(prev_ab_r));
            prev_ab_r      <= track_ab_s;
          end else if (double_s) begin
            error_r   <= 1'b1;
            prev_ab_r <= track_ab_s;
          end
        end
        default: state_r <= ST_INIT;
      endcase
    end
  end

  assign win_last_s = (win_cnt_r == WIN_LAST);

  // Free-running window; the saturating step count is published on the last cycle.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      win_cnt_r  <= '0;
      step_cnt_r <= 4'd0;
      speed_r    <= 4'd0;
    end else if (win_last_s) begin
      win_cnt_r  <= '0;
      step_cnt_r <= 4'd0;
      speed_r    <= (count_enable_r && step_cnt_r != SPEED_MAX) ? step_cnt_r + 4'd1 : step_cnt_r;
    end else begin
      win_cnt_r <= win_cnt_r + WIN_W'(1);
      if (count_enable_r && step_cnt_r != SPEED_MAX) begin
        step_cnt_r <= step_cnt_r + 4'd1;
      end
    end
  end

  assign COUNT_ENABLE = count_enable_r;
  assign DIRECTION    = direction_r;
  assign ERROR        = error_r;
  assign SPEED        = speed_r;

endmodule
